// File: rtl/downcounter_pkg.sv
// rtl/downcounter_pkg.sv - shared constants and helpers for the down counter
package downcounter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Largest value representable in an unsigned counter of the given width.
  function automatic int default_top(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/downcounter.sv
// rtl/downcounter.sv - free-running down counter reloading TOP after 0, with zero/wrap status
module downcounter
  import downcounter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TOP   = default_top(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(TOP);

  generate
    if (TOP < 1 || TOP > default_top(WIDTH)) begin : g_bad_top
      $error("downcounter: TOP must lie in 1..2**WIDTH-1");
    end
  endgenerate

  // wrap is registered alongside counter so it lines up with the reloaded TOP value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= TOP_VAL;
      wrap    <= 1'b0;
    end else if (counter == '0) begin
      counter <= TOP_VAL;
      wrap    <= 1'b1;
    end else begin
      counter <= counter - WIDTH'(1);
      wrap    <= 1'b0;
    end
  end

  assign zero = (counter == '0);

endmodule

// File: tb/tb_downcounter.sv
// tb/tb_downcounter.sv - randomized self-checking bench for downcounter (TOP=15 and TOP=9)
module tb_downcounter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] counter, counter9;
  logic       zero, zero9, wrap, wrap9;

  int checks   = 0;
  int failures = 0;
  int n        = 0;  // rising edges seen since the last reset release

  always #5 clk = ~clk;

  downcounter dut (
    .clk     (clk),
    .reset   (reset),
    .counter (counter),
    .zero    (zero),
    .wrap    (wrap)
  );

  downcounter #(.WIDTH(4), .TOP(9)) dut9 (
    .clk     (clk),
    .reset   (reset),
    .counter (counter9),
    .zero    (zero9),
    .wrap    (wrap9)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: after k edges the count is TOP - (k mod period); a wrap follows each full period.
  function automatic int exp_cnt(input int top, input int edges);
    return top - (edges % (top + 1));
  endfunction

  function automatic int exp_wrap(input int top, input int edges);
    return (edges > 0 && edges % (top + 1) == 0) ? 1 : 0;
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".cnt15"},  32'(counter),  32'(exp_cnt(15, n)));
    chk({ph, ".zero15"}, 32'(zero),     32'(exp_cnt(15, n) == 0));
    chk({ph, ".wrap15"}, 32'(wrap),     32'(exp_wrap(15, n)));
    chk({ph, ".cnt9"},   32'(counter9), 32'(exp_cnt(9, n)));
    chk({ph, ".zero9"},  32'(zero9),    32'(exp_cnt(9, n) == 0));
    chk({ph, ".wrap9"},  32'(wrap9),    32'(exp_wrap(9, n)));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    n++;
    #2;
    check_all(ph);
  endtask

  int wraps15, wraps9, guard, hold, r;

  initial begin
    reset = 1'b1;
    n     = 0;
    #1  check_all("por");
    #8  check_all("por2");
    #11 reset = 1'b0;          // release at 20 ns, between edges
    repeat (18) step("rel");   // covers 1, 0, wrap to F, then E

    // Async reset mid-count at counter == 7, between edges.
    guard = 0;
    while (exp_cnt(15, n) != 7 && guard < 32) begin
      step("seek7");
      guard++;
    end
    chk("seek7.reached", 32'(counter), 32'd7);
    #1 reset = 1'b1;
    n = 0;
    #1 check_all("async");
    #2 check_all("async2");
    @(posedge clk);
    #2 check_all("async_hold");
    #3 reset = 1'b0;
    repeat (4) step("resume");

    // Long run: 100 clocks from a fresh release.
    #1 reset = 1'b1;
    n = 0;
    #1 reset = 1'b0;
    wraps15 = 0;
    wraps9  = 0;
    repeat (100) begin
      step("long");
      if (wrap)  wraps15++;
      if (wrap9) wraps9++;
    end
    chk("long.wraps15", 32'(wraps15), 32'd6);
    chk("long.wraps9",  32'(wraps9),  32'd10);

    // Randomized run lengths and reset pulses at random points between edges.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 40)) step("rnd");
      r    = $urandom_range(0, 5);
      hold = $urandom_range(0, 2);
      #(r) reset = 1'b1;
      n = 0;
      #1 check_all("rnd_rst");
      if (hold == 0) begin
        #1 reset = 1'b0;
      end else begin
        repeat (hold) @(posedge clk);
        #2 check_all("rnd_hold");
        #($urandom_range(1, 5)) reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
